// File: rtl/param_shift_reg_pkg.sv
// param_shift_reg_pkg: shared op codes and FSM states for the universal shift register
package param_shift_reg_pkg;
   localparam int OP_W = 3;
   typedef enum logic [OP_W-1:0] {
      OP_HOLD, OP_LOAD, OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR, OP_CLR
   } op_e;
   typedef enum logic {IDLE, SHIFTING} state_e;
endpackage

// File: rtl/param_shift_reg_step.sv
// shreg_step: one combinational shift/rotate/clear step of the register
module shreg_step
   import param_shift_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_r,
   input  logic             i_si,
   input  op_e              i_op,
   output logic [WIDTH-1:0] o_r,
   output logic             o_so
);
   always_comb begin
      o_r  = i_r;
      o_so = 1'b0;
      case (i_op)
         OP_SHL:  begin o_r = {i_r[WIDTH-2:0], i_si};      o_so = i_r[WIDTH-1]; end
         OP_SHR:  begin o_r = {i_si, i_r[WIDTH-1:1]};      o_so = i_r[0];       end
         OP_ROL:  begin o_r = {i_r[WIDTH-2:0], i_r[WIDTH-1]}; o_so = i_r[WIDTH-1]; end
         OP_ROR:  begin o_r = {i_r[0], i_r[WIDTH-1:1]};    o_so = i_r[0];       end
         OP_ASR:  begin o_r = {i_r[WIDTH-1], i_r[WIDTH-1:1]}; o_so = i_r[0];    end
         OP_CLR:  o_r = '0;
         default: o_r = i_r;
      endcase
   end
endmodule

// File: rtl/param_shift_reg.sv
// param_shift_reg: WIDTH-bit universal register with handshake, clock enable and multi-step shifts
module param_shift_reg
   import param_shift_reg_pkg::*;
#(
   parameter int             WIDTH     = 8,
   parameter int             AMT_W     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [OP_W-1:0]   op,
   input  logic [AMT_W-1:0]  amt,
   input  logic [WIDTH-1:0]  data,
   input  logic              si,
   output logic [WIDTH-1:0]  r,
   output logic              so,
   output logic              busy,
   output logic              done
);
   state_e           r_state;
   op_e              r_op;
   logic [AMT_W-1:0] r_cnt;
   logic             r_done;
   op_e              w_cmd_op, w_op;
   logic             w_acc, w_shift, w_so, w_so_we;
   logic [WIDTH-1:0] w_r;
   assign w_cmd_op  = op_e'(op);
   assign busy      = r_state == SHIFTING;
   assign cmd_ready = ena & ~busy;
   assign done      = r_done & ena;
   assign w_acc     = cmd_valid & cmd_ready;
   assign w_shift   = w_cmd_op inside {OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR};
   // while shifting, the captured op drives the step, not the live input
   assign w_op      = busy ? r_op : w_cmd_op;
   assign w_so_we   = !(w_op inside {OP_HOLD, OP_LOAD});
   shreg_step #(.WIDTH(WIDTH)) u_step (
      .i_r  (r),
      .i_si (si),
      .i_op (w_op),
      .o_r  (w_r),
      .o_so (w_so)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         r       <= RESET_VAL;
         so      <= 1'b0;
         r_state <= IDLE;
         r_op    <= OP_HOLD;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else if (!ena) begin
         r_done <= 1'b0;
      end else if (busy) begin
         r      <= w_r;
         so     <= w_so;
         r_cnt  <= r_cnt - 1'b1;
         r_done <= r_cnt == AMT_W'(1);
         if (r_cnt == AMT_W'(1)) r_state <= IDLE;
      end else if (w_acc) begin
         r_op   <= w_cmd_op;
         r_done <= !(w_shift && amt > AMT_W'(1));
         if (!(w_shift && amt == '0)) begin
            r <= w_op == OP_LOAD ? data : w_r;
            if (w_so_we) so <= w_so;
         end
         if (w_shift && amt > AMT_W'(1)) begin
            r_state <= SHIFTING;
            r_cnt   <= amt - 1'b1;
         end
      end else begin
         r_done <= 1'b0;
      end
   end
endmodule

// File: tb/tb_param_shift_reg.sv
// tb_param_shift_reg: directed vector table plus randomized run against a cycle-level reference model
module tb_param_shift_reg;
   logic       clk = 1'b0;
   logic       rst = 1'b1, ena = 1'b0, cmd_valid = 1'b0, si = 1'b0;
   logic [2:0] op = '0;
   logic [3:0] amt = '0;
   logic [7:0] data = '0;
   logic [7:0] r;
   logic       cmd_ready, so, busy, done;
   int         n_pass = 0, n_total = 0;
   int         m_r = 0, m_left = 0, m_op = 0;
   bit         m_so = 1'b0, m_done = 1'b0;

   typedef struct {
      bit rst, ena, vld;
      int op, amt, data;
      bit si;
      int r;
      bit so, busy, done, rdy;
   } vec_t;
   vec_t tv[$];

   param_shift_reg #(.WIDTH(8), .AMT_W(4), .RESET_VAL(8'h00)) dut (
      .clk(clk), .rst(rst), .ena(ena), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .op(op), .amt(amt), .data(data), .si(si), .r(r), .so(so), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
   endtask

   // one step of an 8-bit shift/rotate, expressed arithmetically
   function automatic void mstep(input int o, input bit s);
      case (o)
         2: begin m_so = m_r / 128 != 0; m_r = (m_r * 2 + int'(s)) % 256; end
         3: begin m_so = m_r % 2 != 0;   m_r = m_r / 2 + int'(s) * 128; end
         4: begin m_so = m_r / 128 != 0; m_r = (m_r * 2) % 256 + m_r / 128; end
         5: begin m_so = m_r % 2 != 0;   m_r = m_r / 2 + (m_r % 2) * 128; end
         6: begin m_so = m_r % 2 != 0;   m_r = m_r / 2 + (m_r / 128) * 128; end
         7: begin m_so = 1'b0;           m_r = 0; end
         default: ;
      endcase
   endfunction

   task automatic tick();
      if (rst) begin
         m_r = 0; m_so = 1'b0; m_left = 0; m_done = 1'b0;
      end else if (!ena) begin
         m_done = 1'b0;
      end else if (m_left > 0) begin
         mstep(m_op, si);
         m_left--;
         m_done = m_left == 0;
      end else if (cmd_valid) begin
         m_done = 1'b1;
         if (op == 1) m_r = int'(data);
         else if (op >= 2 && op <= 6) begin
            if (amt != 0) begin
               mstep(int'(op), si);
               m_left = int'(amt) - 1;
               m_op = int'(op);
               m_done = m_left == 0;
            end
         end else mstep(int'(op), si);
      end else m_done = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_model();
      chk("rand_r", int'(r), m_r);
      chk("rand_so", int'(so), int'(m_so));
      chk("rand_busy", int'(busy), int'(m_left > 0));
      chk("rand_done", int'(done), int'(m_done & ena));
      chk("rand_ready", int'(cmd_ready), int'(ena && m_left == 0));
   endtask

   initial begin
      //          rst ena vld op amt data  si   r     so busy done rdy
      tv.push_back('{1, 1, 0, 0, 0, 'h00, 0, 'h00, 0, 0, 0, 1});
      tv.push_back('{0, 1, 0, 0, 0, 'h00, 0, 'h00, 0, 0, 0, 1});
      tv.push_back('{0, 1, 1, 1, 0, 'hA5, 0, 'hA5, 0, 0, 1, 1});
      tv.push_back('{0, 1, 0, 0, 0, 'h00, 0, 'hA5, 0, 0, 0, 1});
      tv.push_back('{0, 1, 1, 4, 3, 'h00, 0, 'h4B, 1, 1, 0, 0});
      tv.push_back('{0, 1, 1, 1, 0, 'h55, 0, 'h96, 0, 1, 0, 0});
      tv.push_back('{0, 1, 0, 0, 0, 'h00, 0, 'h2D, 1, 0, 1, 1});
      tv.push_back('{0, 1, 0, 0, 0, 'h00, 0, 'h2D, 1, 0, 0, 1});
      tv.push_back('{0, 1, 1, 1, 0, 'h84, 0, 'h84, 1, 0, 1, 1});
      tv.push_back('{0, 1, 1, 6, 2, 'h00, 0, 'hC2, 0, 1, 0, 0});
      tv.push_back('{0, 1, 0, 0, 0, 'h00, 0, 'hE1, 0, 0, 1, 1});
      tv.push_back('{0, 1, 1, 1, 0, 'hF0, 0, 'hF0, 0, 0, 1, 1});
      tv.push_back('{0, 1, 1, 3, 4, 'h00, 0, 'h78, 0, 1, 0, 0});
      tv.push_back('{0, 0, 0, 0, 0, 'h00, 0, 'h78, 0, 1, 0, 0});
      tv.push_back('{0, 0, 0, 0, 0, 'h00, 0, 'h78, 0, 1, 0, 0});
      tv.push_back('{0, 1, 0, 0, 0, 'h00, 0, 'h3C, 0, 1, 0, 0});
      tv.push_back('{0, 1, 0, 0, 0, 'h00, 0, 'h1E, 0, 1, 0, 0});
      tv.push_back('{0, 1, 0, 0, 0, 'h00, 0, 'h0F, 0, 0, 1, 1});
      tv.push_back('{0, 0, 0, 0, 0, 'h00, 0, 'h0F, 0, 0, 0, 0});
      tv.push_back('{0, 1, 1, 1, 0, 'h3C, 0, 'h3C, 0, 0, 1, 1});
      tv.push_back('{0, 1, 1, 2, 5, 'h00, 1, 'h79, 0, 1, 0, 0});
      tv.push_back('{0, 1, 1, 1, 0, 'h55, 1, 'hF3, 0, 1, 0, 0});
      tv.push_back('{1, 1, 1, 1, 0, 'h55, 0, 'h00, 0, 0, 0, 1});
      tv.push_back('{0, 1, 0, 0, 0, 'h00, 0, 'h00, 0, 0, 0, 1});
      tv.push_back('{0, 1, 1, 2, 0, 'h00, 1, 'h00, 0, 0, 1, 1});
      tv.push_back('{0, 1, 1, 2, 1, 'h00, 1, 'h01, 0, 0, 1, 1});
      tv.push_back('{0, 1, 1, 1, 0, 'hFF, 0, 'hFF, 0, 0, 1, 1});
      tv.push_back('{0, 1, 1, 5, 1, 'h00, 0, 'hFF, 1, 0, 1, 1});
      tv.push_back('{0, 1, 1, 7, 0, 'h00, 0, 'h00, 0, 0, 1, 1});
      @(posedge clk);
      #1;
      for (int i = 0; i < tv.size(); i++) begin
         rst = tv[i].rst; ena = tv[i].ena; cmd_valid = tv[i].vld;
         op = 3'(tv[i].op); amt = 4'(tv[i].amt); data = 8'(tv[i].data); si = tv[i].si;
         tick();
         chk($sformatf("vec%0d_r", i), int'(r), tv[i].r);
         chk($sformatf("vec%0d_so", i), int'(so), int'(tv[i].so));
         chk($sformatf("vec%0d_busy", i), int'(busy), int'(tv[i].busy));
         chk($sformatf("vec%0d_done", i), int'(done), int'(tv[i].done));
         chk($sformatf("vec%0d_ready", i), int'(cmd_ready), int'(tv[i].rdy));
      end
      // SHL by the full width with si=0 empties the register
      rst = 1'b0; ena = 1'b1; cmd_valid = 1'b1; op = 3'd1; data = 8'hC3; si = 1'b0;
      tick();
      op = 3'd2; amt = 4'd8;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("shl_full_r", int'(r), 0);
      chk("shl_full_so", int'(so), 1);
      chk("shl_full_done", int'(done), 1);
      for (int i = 0; i < 3000; i++) begin
         rst       = $urandom_range(0, 99) == 0;
         ena       = $urandom_range(0, 9) < 8;
         cmd_valid = $urandom_range(0, 9) < 6;
         op        = 3'($urandom_range(0, 7));
         amt       = $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
         data      = 8'($urandom_range(0, 255));
         si        = 1'($urandom_range(0, 1));
         tick();
         chk_model();
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/param_shift_reg.md
Name: param_shift_reg

Overview:
- Parametrised successor to the team's 8-bit load register: a WIDTH-bit universal register supporting parallel load, clear, and multi-cycle shift/rotate.
- The clock-gated load is replaced by a true clock enable.
- Commands arrive over a valid/ready handshake and complete with a one-cycle done pulse.
- Used as a datapath working register and as a serial/parallel converter.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- AMT_W, 4, width of the shift-amount field.
- RESET_VAL, 0, value of r after reset (WIDTH bits).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  clock enable; low freezes all state.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- op  in  3  operation code.
- amt  in  AMT_W  shift count for shift/rotate ops.
- data  in  WIDTH  parallel load value.
- si  in  1  serial input, sampled on each shift step.
- r  out  WIDTH  register contents (registered).
- so  out  1  last bit shifted or rotated out (registered).
- busy  out  1  multi-step shift in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: rst=1 at an edge sets r=RESET_VAL, so=0, busy=0, done=0, and clears the step counter. rst outranks ena and everything else. Reset mid-operation aborts the operation with no done pulse.
- ena=0: r, so, busy and the counter hold; done is driven 0; cmd_ready=0.
- cmd_ready = ena & ~busy (combinational). A command is accepted at an edge where cmd_valid & cmd_ready. cmd_valid while not ready is ignored; the requester holds the command.
- Op encoding:
  - 0 HOLD: no change.
  - 1 LOAD: r<=data.
  - 2 SHL: r<={r[W-2:0],si}, so<=r[W-1].
  - 3 SHR: r<={si,r[W-1:1]}, so<=r[0].
  - 4 ROL: so<=r[W-1].
  - 5 ROR: so<=r[0].
  - 6 ASR: r<={r[W-1],r[W-1:1]}, so<=r[0].
  - 7 CLR: r<=0, so<=0.
- LOAD and HOLD leave so unchanged.
- Single-step ops (HOLD, LOAD, CLR, and shift ops with amt<=1): r updates at the accept edge; done=1 for exactly the next cycle. busy never rises.
- amt=0 on a shift op is a no-op that still pulses done.
- amt=N>=2:
  - First step is performed at the accept edge, which also sets busy=1 and loads counter=N-1.
  - Each subsequent enabled edge performs one step and decrements the counter.
  - The edge performing the last step clears busy and raises done for one cycle.
  - Total shifted-in/rotated steps = N exactly; ena-low cycles add latency only.
- op and amt are captured at accept; changes on the inputs during busy are ignored. si is sampled live on every step.
- amt >= WIDTH is legal; the shift simply continues, e.g. SHL by WIDTH with si=0 yields 0.
- Latency: single-step, 1 cycle to done; N-step, N cycles from accept to done (with ena held high).
- Back-to-back: a new command is accepted in the same cycle done is high.

Decomposition:
- Package param_shift_reg_pkg holds the op_e enum (HOLD..CLR, 3 bits) and the OP_W constant.
- One combinational sub-module, shreg_step: inputs r, si, op; outputs next r and the out bit, performing one step.
- The top level contains the handshake, counter/busy FSM (IDLE, SHIFTING), and registers.

Test Plan:
- All scenarios use WIDTH=8.
- Reset: r=0x3C with busy=1, pulse rst one cycle -> r=0x00, so=0, busy=0, done=0, and no done afterwards.
- LOAD: op=1, data=0xA5 -> r=0xA5 after the accept edge, done high exactly 1 cycle, busy stays 0.
- ROL multi-step: r=0xA5, op=4, amt=3 -> busy high for 2 cycles, r=0x2D after 3 edges, so=1, single done pulse, cmd_ready low while busy.
- ASR: r=0x84, op=6, amt=2 -> r=0xE1, so=0, done on the 2nd edge.
- ena stall: r=0xF0, op=3 (SHR), amt=4, si=0, ena low for 2 cycles after the first step -> r frozen and done=0 during the stall, final r=0x0F with exactly 4 shifts, done after 6 cycles.
- Handshake/abort: during a busy SHL, present LOAD 0x55 -> not accepted, r unaffected; then assert rst mid-shift -> r=0x00, busy=0, no done.
